// File: rtl/pipeline_hazard_controller_if.sv
// ============================================================================
// Module   : pipeline_hazard_controller_if
// Purpose  : Hazard-controller signal bundle. The pipeline side drives the
//            hazard inputs and the controller drives the stage enable/flush
//            controls. The counter signals exist only with PERF_COUNTERS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_controller_if
`ifdef PERF_COUNTERS_EN
    #(parameter int CNT_WIDTH = 32)
`endif
    ;
    logic       i_IDEX_memRead;
    logic [4:0] i_IDEX_Rt_5;
    logic [4:0] i_IFID_Rs_5;
    logic [4:0] i_IFID_Rt_5;
    logic       i_IFID_usesRt;
    logic       i_branchTaken;
    logic       i_jump;
    logic       i_jumpRegister;
    logic       i_memReq;
    logic       i_memReady;

    logic       o_PC_enable;
    logic       o_IFID_enable;
    logic       o_IFID_flush;
    logic       o_IDEX_enable;
    logic       o_IDEX_flush;
    logic       o_EXMEM_enable;
    logic       o_EXMEM_flush;
    logic       o_MEMWB_flush;
    logic       o_memTimeout;
    logic [1:0] o_state_2;
`ifdef PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] o_stallCount;
    logic [CNT_WIDTH-1:0] o_flushCount;
    logic [CNT_WIDTH-1:0] o_waitCount;
`endif

    modport master (
        output i_IDEX_memRead, i_IDEX_Rt_5, i_IFID_Rs_5, i_IFID_Rt_5, i_IFID_usesRt,
               i_branchTaken, i_jump, i_jumpRegister, i_memReq, i_memReady,
        input  o_PC_enable, o_IFID_enable, o_IFID_flush, o_IDEX_enable, o_IDEX_flush,
               o_EXMEM_enable, o_EXMEM_flush, o_MEMWB_flush, o_memTimeout, o_state_2
`ifdef PERF_COUNTERS_EN
        , input o_stallCount, o_flushCount, o_waitCount
`endif
    );

    modport slave (
        input  i_IDEX_memRead, i_IDEX_Rt_5, i_IFID_Rs_5, i_IFID_Rt_5, i_IFID_usesRt,
               i_branchTaken, i_jump, i_jumpRegister, i_memReq, i_memReady,
        output o_PC_enable, o_IFID_enable, o_IFID_flush, o_IDEX_enable, o_IDEX_flush,
               o_EXMEM_enable, o_EXMEM_flush, o_MEMWB_flush, o_memTimeout, o_state_2
`ifdef PERF_COUNTERS_EN
        , output o_stallCount, o_flushCount, o_waitCount
`endif
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : 5-stage pipeline sequencer. It handles load-use stalls,
//            branch/jump flushes and data-memory waits with a timeout.
//            Optional macro PERF_COUNTERS_EN adds saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_controller #(
    parameter int MEM_WAIT_MAX = 16
`ifdef PERF_COUNTERS_EN
    , parameter int CNT_WIDTH  = 32
`endif
) (
    input  wire                          clk,
    input  wire                          reset,
    pipeline_hazard_controller_if.slave  bus
);

    localparam int c_WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_WAIT_MAX);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_FLUSH      = 2'd2,
        S_MEM_WAIT   = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_WAIT_W-1:0]   r_waitCnt;

    state_t                w_nextState;
    logic [c_WAIT_W-1:0]   w_nextWaitCnt;
    logic                  w_loadUse;
    logic                  w_pcEn, w_ifidEn, w_ifidFl, w_idexEn, w_idexFl;
    logic                  w_exmemEn, w_exmemFl, w_memwbFl, w_timeout;
    logic                  w_stallEvt, w_flushEvt;

    // A load into $0 never produces a value a consumer could wait for.
    assign w_loadUse = bus.i_IDEX_memRead && (bus.i_IDEX_Rt_5 != 5'd0) &&
                       ((bus.i_IDEX_Rt_5 == bus.i_IFID_Rs_5) ||
                        (bus.i_IFID_usesRt && (bus.i_IDEX_Rt_5 == bus.i_IFID_Rt_5)));

    always_comb begin
        w_nextState   = S_RUN;
        w_nextWaitCnt = '0;
        w_pcEn        = 1'b1;
        w_ifidEn      = 1'b1;
        w_ifidFl      = 1'b0;
        w_idexEn      = 1'b1;
        w_idexFl      = 1'b0;
        w_exmemEn     = 1'b1;
        w_exmemFl     = 1'b0;
        w_memwbFl     = 1'b0;
        w_timeout     = 1'b0;
        w_stallEvt    = 1'b0;
        w_flushEvt    = 1'b0;

        if (r_state == S_MEM_WAIT) begin
            // Redirects are ignored here; they are re-evaluated once back in RUN.
            if (bus.i_memReady) begin
                w_nextState = S_RUN;
            end else if (r_waitCnt == c_WAIT_MAX) begin
                w_timeout   = 1'b1;
                w_exmemFl   = 1'b1;
            end else begin
                w_pcEn        = 1'b0;
                w_ifidEn      = 1'b0;
                w_idexEn      = 1'b0;
                w_exmemEn     = 1'b0;
                w_memwbFl     = 1'b1;
                w_nextState   = S_MEM_WAIT;
                w_nextWaitCnt = r_waitCnt + c_WAIT_W'(1);
            end
        end else if (bus.i_memReq && !bus.i_memReady) begin
            w_pcEn        = 1'b0;
            w_ifidEn      = 1'b0;
            w_idexEn      = 1'b0;
            w_exmemEn     = 1'b0;
            w_memwbFl     = 1'b1;
            w_nextState   = S_MEM_WAIT;
            w_nextWaitCnt = c_WAIT_W'(1);
        end else if (bus.i_branchTaken) begin
            w_ifidFl    = 1'b1;
            w_idexFl    = 1'b1;
            w_exmemFl   = 1'b1;
            w_flushEvt  = 1'b1;
            w_nextState = S_FLUSH;
        end else if (bus.i_jump || bus.i_jumpRegister) begin
            w_ifidFl    = 1'b1;
            w_idexFl    = 1'b1;
            w_flushEvt  = 1'b1;
            w_nextState = S_FLUSH;
        end else if ((r_state == S_RUN) && w_loadUse) begin
            // LOAD_STALL/FLUSH hold a bubble in ID/EX, so detection is masked there.
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexFl    = 1'b1;
            w_stallEvt  = 1'b1;
            w_nextState = S_LOAD_STALL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RUN;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    // Every control is forced low while reset is held.
    assign bus.o_PC_enable    = reset & w_pcEn;
    assign bus.o_IFID_enable  = reset & w_ifidEn;
    assign bus.o_IFID_flush   = reset & w_ifidFl;
    assign bus.o_IDEX_enable  = reset & w_idexEn;
    assign bus.o_IDEX_flush   = reset & w_idexFl;
    assign bus.o_EXMEM_enable = reset & w_exmemEn;
    assign bus.o_EXMEM_flush  = reset & w_exmemFl;
    assign bus.o_MEMWB_flush  = reset & w_memwbFl;
    assign bus.o_memTimeout   = reset & w_timeout;
    assign bus.o_state_2      = r_state;

`ifdef PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] r_stallCount;
    logic [CNT_WIDTH-1:0] r_flushCount;
    logic [CNT_WIDTH-1:0] r_waitCount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
            r_waitCount  <= '0;
        end else begin
            if (w_stallEvt && (r_stallCount != '1))
                r_stallCount <= r_stallCount + CNT_WIDTH'(1);
            if (w_flushEvt && (r_flushCount != '1))
                r_flushCount <= r_flushCount + CNT_WIDTH'(1);
            if ((r_state == S_MEM_WAIT) && (r_waitCount != '1))
                r_waitCount  <= r_waitCount + CNT_WIDTH'(1);
        end
    end

    assign bus.o_stallCount = r_stallCount;
    assign bus.o_flushCount = r_flushCount;
    assign bus.o_waitCount  = r_waitCount;
`else
    logic w_unusedEvt;
    assign w_unusedEvt = w_stallEvt ^ w_flushEvt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Directed bench for pipeline_hazard_controller with MEM_WAIT_MAX=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller_if bus ();

    pipeline_hazard_controller #(.MEM_WAIT_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Packed order: PCen IFIDen IFIDfl IDEXen IDEXfl EXMEMen EXMEMfl MEMWBfl timeout state[1:0]
    localparam logic [10:0] c_ZERO  = 11'b0_00_00_00_0_0_00;
    localparam logic [10:0] c_DEF   = 11'b1_10_10_10_0_0_00;
    localparam logic [10:0] c_LU    = 11'b0_00_11_10_0_0_00;
    localparam logic [10:0] c_LSDEF = 11'b1_10_10_10_0_0_01;
    localparam logic [10:0] c_BR    = 11'b1_11_11_11_0_0_00;
    localparam logic [10:0] c_JMP   = 11'b1_11_11_10_0_0_00;
    localparam logic [10:0] c_FLDEF = 11'b1_10_10_10_0_0_10;
    localparam logic [10:0] c_FRZ0  = 11'b0_00_00_00_1_0_00;
    localparam logic [10:0] c_FRZ3  = 11'b0_00_00_00_1_0_11;
    localparam logic [10:0] c_RDY   = 11'b1_10_10_10_0_0_11;
    localparam logic [10:0] c_TO    = 11'b1_10_10_11_0_1_11;

    function automatic logic [10:0] observe();
        return {bus.o_PC_enable, bus.o_IFID_enable, bus.o_IFID_flush,
                bus.o_IDEX_enable, bus.o_IDEX_flush, bus.o_EXMEM_enable,
                bus.o_EXMEM_flush, bus.o_MEMWB_flush, bus.o_memTimeout,
                bus.o_state_2};
    endfunction

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        #1;
        obs = observe();
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_IDEX_memRead = 1'b0;
        bus.i_IDEX_Rt_5    = 5'd0;
        bus.i_IFID_Rs_5    = 5'd0;
        bus.i_IFID_Rt_5    = 5'd0;
        bus.i_IFID_usesRt  = 1'b0;
        bus.i_branchTaken  = 1'b0;
        bus.i_jump         = 1'b0;
        bus.i_jumpRegister = 1'b0;
        bus.i_memReq       = 1'b0;
        bus.i_memReady     = 1'b0;
    endtask

    initial begin
        idle();
        #3 chk("reset_hold", c_ZERO);
        tick();
        reset = 1'b1;
        chk("reset_release", c_DEF);

        // lw $t0 ; add $t1,$t0,$t2
        tick();
        bus.i_IDEX_memRead = 1'b1; bus.i_IDEX_Rt_5 = 5'd8;
        bus.i_IFID_Rs_5 = 5'd8; bus.i_IFID_Rt_5 = 5'd10; bus.i_IFID_usesRt = 1'b1;
        chk("lu_stall", c_LU);
        tick();
        chk("lu_masked", c_LSDEF);
        tick();
        idle();
        chk("lu_back_run", c_DEF);

        // $0 never stalls; rt match only counts when rt is read
        tick();
        bus.i_IDEX_memRead = 1'b1; bus.i_IDEX_Rt_5 = 5'd0;
        bus.i_IFID_Rs_5 = 5'd0; bus.i_IFID_Rt_5 = 5'd0; bus.i_IFID_usesRt = 1'b1;
        chk("lu_zero_reg", c_DEF);
        bus.i_IDEX_Rt_5 = 5'd8; bus.i_IFID_Rs_5 = 5'd9; bus.i_IFID_Rt_5 = 5'd8;
        chk("lu_rt_used", c_LU);
        bus.i_IFID_usesRt = 1'b0;
        chk("lu_rt_unused", c_DEF);
        tick();
        idle();
        chk("lu_rt_unused_run", c_DEF);

        // taken branch
        tick();
        bus.i_branchTaken = 1'b1;
        chk("branch", c_BR);
        tick();
        bus.i_branchTaken = 1'b0;
        chk("branch_flush_state", c_FLDEF);
        tick();
        chk("branch_exit", c_DEF);

        // jr, then a load-use pattern during FLUSH is masked
        tick();
        bus.i_jumpRegister = 1'b1;
        chk("jump_reg", c_JMP);
        tick();
        bus.i_jumpRegister = 1'b0;
        bus.i_IDEX_memRead = 1'b1; bus.i_IDEX_Rt_5 = 5'd8; bus.i_IFID_Rs_5 = 5'd8;
        chk("flush_masks_lu", c_FLDEF);
        tick();
        idle();
        bus.i_jump = 1'b1;
        chk("jump", c_JMP);
        tick();
        bus.i_jump = 1'b0;
        chk("jump_flush_state", c_FLDEF);
        tick();
        chk("jump_exit", c_DEF);

        // memory not ready for 3 cycles
        tick();
        bus.i_memReq = 1'b1;
        chk("mw_enter", c_FRZ0);
        tick();
        chk("mw_cnt1", c_FRZ3);
        tick();
        chk("mw_cnt2", c_FRZ3);
        tick();
        bus.i_memReady = 1'b1;
        chk("mw_ready", c_RDY);
        tick();
        idle();
        chk("mw_exit", c_DEF);

        // memory never ready: timeout at count 4; branch during wait ignored
        tick();
        bus.i_memReq = 1'b1;
        chk("to_enter", c_FRZ0);
        tick();
        chk("to_cnt1", c_FRZ3);
        tick();
        bus.i_branchTaken = 1'b1;
        chk("to_cnt2_branch_ignored", c_FRZ3);
        tick();
        bus.i_branchTaken = 1'b0;
        chk("to_cnt3", c_FRZ3);
        tick();
        chk("to_pulse", c_TO);
        tick();
        idle();
        chk("to_after", c_DEF);

        // memory wait beats branch; reset during wait aborts at once
        tick();
        bus.i_memReq = 1'b1; bus.i_branchTaken = 1'b1;
        chk("prio_mem_over_branch", c_FRZ0);
        tick();
        bus.i_branchTaken = 1'b0;
        chk("prio_in_wait", c_FRZ3);
        #2 reset = 1'b0;
        chk("reset_mid_wait", c_ZERO);
        tick();
        chk("reset_held", c_ZERO);
        idle();
        reset = 1'b1;
        chk("reset_after_wait", c_DEF);
        tick();
        chk("reset_after_wait_next", c_DEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
